// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, byte/word helpers, controller state encoding and
// the legal key-length/round-count pairs.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic bit legal_nk_nr(input int nk, input int nr);
        return ((nk == 4) && (nr == 10)) || ((nk == 6) && (nr == 12)) || ((nk == 8) && (nr == 14));
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: byte-wise S-box substitution of one 32-bit word, shared with the cipher rounds.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key-schedule sequencer: expands one schedule word per clock into a local
// word store, then serves aligned 128-bit round keys on request.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [Nk*32-1:0] key,
    output logic             busy,
    output logic             done,
    input  logic             rk_req,
    input  logic [3:0]       rk_idx,
    output logic             rk_ready,
    output logic             rk_valid,
    output logic [127:0]     rk,
    output logic             rk_err
);

    localparam int         NW         = 4 * (Nr + 1);
    localparam logic [5:0] NK_W       = 6'(Nk);
    localparam logic [5:0] LAST_W     = 6'(NW - 1);
    localparam logic [2:0] CNT_RELOAD = 3'(Nk - 1);
    localparam logic [3:0] NR_W       = 4'(Nr);
    localparam bit         WIDE_KEY   = (Nk > 6);

    if (!legal_nk_nr(Nk, Nr)) begin : g_bad_cfg
        $fatal(1, "aes_key_sched_ctrl: unsupported Nk/Nr combination");
    end

    state_e        state_q, state_d;
    logic [5:0]    i_q, i_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [31:0]   w_q [NW];
    logic [31:0]   w_d [NW];
    logic          done_q, done_d;
    logic          rk_valid_q, rk_valid_d;
    logic          rk_err_q, rk_err_d;
    logic [127:0]  rk_q, rk_d;

    logic          key_xfer;
    logic          rd_accept;
    logic [5:0]    rd_base;
    logic [31:0]   prev_word;
    logic [31:0]   back_word;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   temp_word;
    logic [31:0]   new_word;

    assign key_ready = (state_q == ST_IDLE) || (state_q == ST_READY);
    assign busy      = (state_q == ST_EXPAND);
    assign key_xfer  = key_valid && key_ready;
    // A key offered in the same cycle as a read takes priority, so the read is refused.
    assign rd_accept = rk_req && (state_q == ST_READY) && !key_valid;
    assign rk_ready  = rd_accept;
    assign rd_base   = {rk_idx, 2'b00};

    assign done      = done_q;
    assign rk_valid  = rk_valid_q;
    assign rk        = rk_q;
    assign rk_err    = rk_err_q;

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    // cnt_q is the distance to the next rcon word: zero means i mod Nk == 0.
    always_comb begin
        prev_word = w_q[i_q - 6'd1];
        back_word = w_q[i_q - NK_W];
        sub_in    = prev_word;
        temp_word = prev_word;
        if (cnt_q == 3'd0) begin
            sub_in    = rot_word(prev_word);
            temp_word = sub_out ^ {rcon_q, 24'h000000};
        end else if (WIDE_KEY && (cnt_q == 3'd4)) begin
            temp_word = sub_out;
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        w_d        = w_q;
        done_d     = 1'b0;
        rk_valid_d = 1'b0;
        rk_d       = rk_q;
        rk_err_d   = rk_err_q;

        if (key_xfer) begin
            for (int k = 0; k < Nk; k++) begin
                w_d[k] = key[Nk*32-1-32*k -: 32];
            end
        end else begin
            w_d = w_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (key_xfer) begin
                    state_d = ST_EXPAND;
                    i_d     = NK_W;
                    cnt_d   = 3'd0;
                    rcon_d  = 8'h01;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                w_d[i_q] = new_word;
                i_d      = i_q + 6'd1;
                if (cnt_q == 3'd0) begin
                    cnt_d  = CNT_RELOAD;
                    rcon_d = xtime(rcon_q);
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                end
                if (i_q == LAST_W) begin
                    state_d = ST_READY;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            ST_READY: begin
                if (key_xfer) begin
                    state_d = ST_EXPAND;
                    i_d     = NK_W;
                    cnt_d   = 3'd0;
                    rcon_d  = 8'h01;
                end else if (rd_accept) begin
                    rk_valid_d = 1'b1;
                    if (rk_idx > NR_W) begin
                        rk_err_d = 1'b1;
                        rk_d     = 128'h0;
                    end else begin
                        rk_err_d = 1'b0;
                        rk_d     = {w_q[rd_base], w_q[rd_base + 6'd1],
                                    w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All controller state, the word store and the registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_q        <= 6'd0;
            cnt_q      <= 3'd0;
            rcon_q     <= 8'h00;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_q       <= 128'h0;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            cnt_q      <= cnt_d;
            rcon_q     <= rcon_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            rk_err_q   <= rk_err_d;
            rk_q       <= rk_d;
            w_q        <= w_d;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: AES-128/192/256 instances against a FIPS-197 style expansion
// model whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] kin;
    logic         kv    [3];
    logic         kr    [3];
    logic         bsy   [3];
    logic         dn    [3];
    logic         rq    [3];
    logic [3:0]   ridx  [3];
    logic         rrdy  [3];
    logic         rval  [3];
    logic [127:0] rkv   [3];
    logic         rerr  [3];

    logic [7:0]   sb [256];
    logic [31:0]  mw [3][60];
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.Nk(4), .Nr(10)) u128 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_ready(kr[0]), .key(kin[255:128]),
        .busy(bsy[0]), .done(dn[0]), .rk_req(rq[0]), .rk_idx(ridx[0]), .rk_ready(rrdy[0]),
        .rk_valid(rval[0]), .rk(rkv[0]), .rk_err(rerr[0]));
    aes_key_sched_ctrl #(.Nk(6), .Nr(12)) u192 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]), .key(kin[255:64]),
        .busy(bsy[1]), .done(dn[1]), .rk_req(rq[1]), .rk_idx(ridx[1]), .rk_ready(rrdy[1]),
        .rk_valid(rval[1]), .rk(rkv[1]), .rk_err(rerr[1]));
    aes_key_sched_ctrl #(.Nk(8), .Nr(14)) u256 (
        .clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]), .key(kin),
        .busy(bsy[2]), .done(dn[2]), .rk_req(rq[2]), .rk_idx(ridx[2]), .rk_ready(rrdy[2]),
        .rk_valid(rval[2]), .rk(rkv[2]), .rk_err(rerr[2]));

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nk_of(input int c);
        return (c == 0) ? 4 : ((c == 1) ? 6 : 8);
    endfunction

    function automatic int nr_of(input int c);
        return nk_of(c) + 6;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            end
            sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic build_model(input int c, input logic [255:0] k);
        int nk = nk_of(c);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int j = 0; j < nk; j++) mw[c][j] = k[255-32*j -: 32];
        for (int i = nk; i < 4 * (nr_of(c) + 1); i++) begin
            t = mw[c][i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int p = 1; p < i / nk; p++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            mw[c][i] = mw[c][i-nk] ^ t;
        end
    endtask

    function automatic logic [128:0] exp_rk(input int c, input int idx);
        if (idx > nr_of(c)) return {1'b1, 128'h0};
        return {1'b0, mw[c][4*idx], mw[c][4*idx+1], mw[c][4*idx+2], mw[c][4*idx+3]};
    endfunction

    task automatic check_reset(input int c);
        check_eq($sformatf("c%0d rst key_ready", c), kr[c], 1'b1);
        check_eq($sformatf("c%0d rst busy", c), bsy[c], 1'b0);
        check_eq($sformatf("c%0d rst done", c), dn[c], 1'b0);
        check_eq($sformatf("c%0d rst rk_valid", c), rval[c], 1'b0);
        check_eq($sformatf("c%0d rst rk", c), rkv[c], 128'h0);
        check_eq($sformatf("c%0d rst rk_err", c), rerr[c], 1'b0);
        rq[c] = 1'b1;
        #1;
        check_eq($sformatf("c%0d idle rk_ready", c), rrdy[c], 1'b0);
        @(posedge clk); #1;
        rq[c] = 1'b0;
        check_eq($sformatf("c%0d idle no rk_valid", c), rval[c], 1'b0);
    endtask

    // Entered one step after the key-transfer edge; returns one step after the done edge.
    task automatic expand_wait(input int c, input bit noise);
        int lat = 4 * (nr_of(c) + 1) - nk_of(c);
        int cyc = 0;
        int busy_cnt = 0;
        int viol = 0;
        while (dn[c] !== 1'b1 && cyc < 200) begin
            if (bsy[c] === 1'b1) busy_cnt++;
            if (noise) begin
                kv[c] = 1'($urandom);
                rq[c] = 1'($urandom);
                ridx[c] = 4'($urandom);
                kin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                #1;
                if (kr[c] !== 1'b0 || rrdy[c] !== 1'b0 || rval[c] !== 1'b0) viol++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        kv[c] = 1'b0;
        rq[c] = 1'b0;
        check_eq($sformatf("c%0d done latency", c), cyc, lat);
        check_eq($sformatf("c%0d busy cycles", c), busy_cnt, lat);
        check_eq($sformatf("c%0d busy after done", c), bsy[c], 1'b0);
        if (noise) check_eq($sformatf("c%0d expand handshakes", c), viol, 0);
        @(posedge clk); #1;
        check_eq($sformatf("c%0d done one cycle", c), dn[c], 1'b0);
    endtask

    task automatic load_key(input int c, input logic [255:0] k, input bit noise);
        int cyc = 0;
        while (kr[c] !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq($sformatf("c%0d key_ready", c), kr[c], 1'b1);
        kin = k;
        kv[c] = 1'b1;
        @(posedge clk); #1;
        kv[c] = 1'b0;
        build_model(c, k);
        expand_wait(c, noise);
    endtask

    task automatic read_burst(input int c, input int idxs[$]);
        logic [128:0] e = '0;
        for (int j = 0; j < idxs.size(); j++) begin
            rq[c] = 1'b1;
            ridx[c] = 4'(idxs[j]);
            #1;
            check_eq($sformatf("c%0d rk_ready %0d", c, idxs[j]), rrdy[c], 1'b1);
            @(posedge clk); #1;
            rq[c] = 1'b0;
            e = exp_rk(c, idxs[j]);
            check_eq($sformatf("c%0d rk_valid %0d", c, idxs[j]), rval[c], 1'b1);
            check_eq($sformatf("c%0d rk_err %0d", c, idxs[j]), rerr[c], e[128]);
            check_eq($sformatf("c%0d rk %0d", c, idxs[j]), rkv[c], e[127:0]);
        end
        @(posedge clk); #1;
        check_eq($sformatf("c%0d rk_valid idle", c), rval[c], 1'b0);
        check_eq($sformatf("c%0d rk hold", c), rkv[c], e[127:0]);
    endtask

    initial begin
        int q[$];
        logic [255:0] k;
        logic [127:0] old_rk;
        logic [128:0] e;

        rst = 1'b1;
        kin = '0;
        for (int c = 0; c < 3; c++) begin
            kv[c] = 1'b0;
            rq[c] = 1'b0;
            ridx[c] = 4'd0;
        end
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) check_reset(c);

        load_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        q = {10};
        read_burst(0, q);
        check_eq("aes128 vec rk10", rkv[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        load_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
        q = {};
        for (int r = 0; r <= 10; r++) q.push_back(r);
        read_burst(0, q);
        check_eq("aes128 seq rk10", rkv[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        q = {0};
        read_burst(0, q);
        check_eq("aes128 seq rk0", rkv[0], 128'h000102030405060708090a0b0c0d0e0f);

        load_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0);
        q = {14};
        read_burst(2, q);
        check_eq("aes256 rk14", rkv[2], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        load_key(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b0);
        q = {12};
        read_burst(1, q);
        check_eq("aes192 w51", rkv[1][31:0], 32'h01002202);
        q = {13};
        read_burst(1, q);
        check_eq("aes192 idx13 err", rerr[1], 1'b1);
        check_eq("aes192 idx13 rk", rkv[1], 128'h0);

        k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        load_key(0, k, 1'b1);
        q = {};
        for (int r = 0; r <= 10; r++) q.push_back(r);
        read_burst(0, q);

        // Read accepted, then a new key the next cycle alongside another request.
        rq[0] = 1'b1;
        ridx[0] = 4'd3;
        #1;
        check_eq("swap rk_ready", rrdy[0], 1'b1);
        @(posedge clk); #1;
        e = exp_rk(0, 3);
        old_rk = e[127:0];
        k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        kin = k;
        kv[0] = 1'b1;
        ridx[0] = 4'd5;
        #1;
        check_eq("swap key wins", rrdy[0], 1'b0);
        check_eq("swap old valid", rval[0], 1'b1);
        check_eq("swap old rk", rkv[0], old_rk);
        @(posedge clk); #1;
        kv[0] = 1'b0;
        rq[0] = 1'b0;
        check_eq("swap no second read", rval[0], 1'b0);
        check_eq("swap busy", bsy[0], 1'b1);
        build_model(0, k);
        expand_wait(0, 1'b0);
        q = {};
        for (int r = 0; r <= 10; r++) q.push_back(r);
        read_burst(0, q);

        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < 3; c++) begin
                k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                load_key(c, k, it == 1);
                q = {};
                for (int r = 0; r < 8; r++) q.push_back(int'($urandom_range(0, 15)));
                read_burst(c, q);
            end
        end

        // Reset in the middle of an AES-256 expansion, then a fresh key.
        kin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        kv[2] = 1'b1;
        @(posedge clk); #1;
        kv[2] = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check_eq("mid busy before rst", bsy[2], 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset(2);
        begin
            int pulses = 0;
            for (int n = 0; n < 60; n++) begin
                @(posedge clk); #1;
                if (dn[2] === 1'b1 || bsy[2] === 1'b1) pulses++;
            end
            check_eq("no done after rst", pulses, 0);
        end
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        load_key(2, k, 1'b0);
        q = {};
        for (int r = 0; r <= 15; r++) q.push_back(r);
        read_burst(2, q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
